// File: rtl/cache_bus_arbiter_pkg.sv
// Shared types for the cache bus: bus FSM states, requester IDs and the
// grant priority decision used when the bus is idle.
package cache_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } busstate_t;

  typedef enum logic {
    REQ_IFU = 1'b0,
    REQ_LSU = 1'b1
  } reqid_t;

  // First matching rule wins. A D$ writeback is normally followed by the
  // refill of the same set, so the LSU keeps the bus for that fill before
  // the I$ gets its fairness turn.
  function automatic reqid_t arbitrate(
    input logic   ifu_req,
    input logic   lsu_fill,
    input logic   lsu_req,
    input reqid_t last_grant,
    input logic   last_write
  );
    reqid_t g;
    if (last_write && lsu_fill)                g = REQ_LSU;
    else if (last_grant == REQ_LSU && ifu_req) g = REQ_IFU;
    else if (lsu_req)                          g = REQ_LSU;
    else                                       g = REQ_IFU;
    return g;
  endfunction

endpackage

// File: rtl/cache_bus_arbiter_busbeatcounter.sv
// Beat counter for one burst: an enabled, resettable register that counts
// accepted beats and flags the final beat of the line. It wraps to zero
// after the final beat, so it is already cleared for the next burst.
module cache_bus_arbiter_busbeatcounter #(
  parameter int LOGBWPL = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  output logic [LOGBWPL-1:0] count_o,
  output logic               final_o
);

  logic [LOGBWPL-1:0] count_q;
  logic [LOGBWPL-1:0] count_d;

  assign count_d = count_q + LOGBWPL'(1);

  // Advance on every accepted beat; natural wrap returns to beat 0.
  always_ff @(posedge clk_i) begin
    if (reset_i)   count_q <= '0;
    else if (en_i) count_q <= count_d;
  end

  assign count_o = count_q;
  assign final_o = &count_q;

endmodule

// File: rtl/cache_bus_arbiter.sv
// Arbiter sharing the beat-oriented memory bus between the I$ (line fills)
// and the D$ (line fills and dirty writebacks). One requester owns the bus
// for a whole burst; the beat counter and fill buffer are shared by both.
module cache_bus_arbiter
  import cache_bus_arbiter_pkg::*;
#(
  parameter int PA_BITS = 34,
  parameter int LINELEN = 512,
  parameter int AHBW    = 64,
  parameter int LOGBWPL = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         IFUCacheBusRW,
  input  logic [PA_BITS-1:0] IFUCacheBusAdr,
  output logic               IFUCacheBusAck,
  input  logic [1:0]         LSUCacheBusRW,
  input  logic [PA_BITS-1:0] LSUCacheBusAdr,
  input  logic [AHBW-1:0]    LSUWriteData,
  output logic               LSUCacheBusAck,
  output logic               LSUSelBusBeat,
  output logic [LOGBWPL-1:0] BeatCount,
  output logic [LINELEN-1:0] FetchBuffer,
  output logic               BusReq,
  output logic               BusWrite,
  output logic [PA_BITS-1:0] BusAdr,
  output logic [AHBW-1:0]    BusWData,
  input  logic               BusReady,
  input  logic [AHBW-1:0]    BusRData
);

  localparam int NBEATS  = LINELEN / AHBW;
  localparam int BYTE_SH = $clog2(AHBW / 8);

  busstate_t          state_q, state_d;
  reqid_t             grant_q, grant_d;
  reqid_t             last_grant_q;
  logic               write_q, write_d;
  logic               last_write_q;
  logic [PA_BITS-1:0] adr_q, adr_d;
  logic [AHBW-1:0]    fb_q [NBEATS];

  logic ifu_req, lsu_fill, lsu_wb, lsu_req, any_req;
  logic in_burst, beat_en, final_beat, last_ready, grab;
  logic [LOGBWPL-1:0] beat;

  // The I$ never writes back, so its RW[0] carries no meaning here.
  logic unused_ifu_rw0;
  assign unused_ifu_rw0 = IFUCacheBusRW[0];

  assign ifu_req  = IFUCacheBusRW[1];
  assign lsu_fill = LSUCacheBusRW[1];
  assign lsu_wb   = LSUCacheBusRW[0];
  assign lsu_req  = lsu_fill | lsu_wb;
  assign any_req  = ifu_req | lsu_req;

  assign in_burst   = (state_q == BURST);
  assign beat_en    = in_burst & BusReady;
  assign last_ready = beat_en & final_beat;
  assign grab       = (state_q == IDLE) & any_req;

  // Grant decision, valid only while idle; captured when the burst starts.
  assign grant_d = arbitrate(ifu_req, lsu_fill, lsu_req, last_grant_q, last_write_q);
  assign write_d = (grant_d == REQ_LSU) & lsu_wb;
  assign adr_d   = (grant_d == REQ_LSU) ? LSUCacheBusAdr : IFUCacheBusAdr;

  cache_bus_arbiter_busbeatcounter #(
    .LOGBWPL (LOGBWPL)
  ) u_beatcnt (
    .clk_i   (clk),
    .reset_i (reset),
    .en_i    (beat_en),
    .count_o (beat),
    .final_o (final_beat)
  );

  // Bus FSM next-state and bus request.
  always_comb begin
    state_d = state_q;
    BusReq  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) state_d = BURST;
      end
      BURST: begin
        BusReq = 1'b1;
        if (last_ready) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state: FSM, latched grant/direction and arbitration history.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= REQ_IFU;
      write_q      <= 1'b0;
      last_grant_q <= REQ_IFU;
      last_write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grab) begin
        grant_q <= grant_d;
        write_q <= write_d;
      end
      if (last_ready) begin
        last_grant_q <= grant_q;
        last_write_q <= write_q;
      end
    end
  end

  // Burst base address, held for the whole burst.
  always_ff @(posedge clk) begin
    if (grab) adr_q <= adr_d;
  end

  // Fill buffer: each read beat lands in its slot; contents persist
  // between bursts so the caches can read the line after the Ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NBEATS; i++) fb_q[i] <= '0;
    end else if (beat_en && !write_q) begin
      fb_q[beat] <= BusRData;
    end
  end

  for (genvar b = 0; b < NBEATS; b++) begin : g_fb
    assign FetchBuffer[b*AHBW +: AHBW] = fb_q[b];
  end

  assign BeatCount      = beat;
  assign BusWrite       = in_burst & write_q;
  assign BusAdr         = adr_q + (PA_BITS'(beat) << BYTE_SH);
  assign BusWData       = LSUWriteData;
  assign IFUCacheBusAck = last_ready & (grant_q == REQ_IFU);
  assign LSUCacheBusAck = last_ready & (grant_q == REQ_LSU);
  assign LSUSelBusBeat  = (state_q != IDLE) & (grant_q == REQ_LSU);

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter: a per-cycle vector table covering
// arbitration, addressing, acks and fill-buffer assembly, followed by
// hand-written sequences for mid-burst reset and request withdrawal.
module tb_cache_bus_arbiter;

  localparam int PA = 34;
  localparam int LL = 512;
  localparam int W  = 64;
  localparam int LB = 3;
  localparam logic [PA-1:0] IADR = 34'h0_8000_0040;

  logic          clk, reset;
  logic [1:0]    IFUCacheBusRW, LSUCacheBusRW;
  logic [PA-1:0] IFUCacheBusAdr, LSUCacheBusAdr, BusAdr;
  logic          IFUCacheBusAck, LSUCacheBusAck, LSUSelBusBeat;
  logic [W-1:0]  LSUWriteData, BusWData, BusRData;
  logic [LB-1:0] BeatCount;
  logic [LL-1:0] FetchBuffer;
  logic          BusReq, BusWrite, BusReady;

  cache_bus_arbiter #(.PA_BITS(PA), .LINELEN(LL), .AHBW(W), .LOGBWPL(LB)) dut (
    .clk            (clk),
    .reset          (reset),
    .IFUCacheBusRW  (IFUCacheBusRW),
    .IFUCacheBusAdr (IFUCacheBusAdr),
    .IFUCacheBusAck (IFUCacheBusAck),
    .LSUCacheBusRW  (LSUCacheBusRW),
    .LSUCacheBusAdr (LSUCacheBusAdr),
    .LSUWriteData   (LSUWriteData),
    .LSUCacheBusAck (LSUCacheBusAck),
    .LSUSelBusBeat  (LSUSelBusBeat),
    .BeatCount      (BeatCount),
    .FetchBuffer    (FetchBuffer),
    .BusReq         (BusReq),
    .BusWrite       (BusWrite),
    .BusAdr         (BusAdr),
    .BusWData       (BusWData),
    .BusReady       (BusReady),
    .BusRData       (BusRData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [1:0]    irw;
    logic [1:0]    lrw;
    logic [PA-1:0] ladr;
    logic          rdy;
    logic          eq;
    logic          ew;
    logic [LB-1:0] eb;
    logic          eia;
    logic          ela;
    logic          esel;
    logic [PA-1:0] eadr;
    logic          chkfb;
  } vec_t;

  vec_t          vq[$];
  int            checks = 0;
  int            errors = 0;
  logic [LL-1:0] fb_exp;

  task automatic push(input logic rst, input logic [1:0] irw, input logic [1:0] lrw,
                      input logic [PA-1:0] ladr, input logic rdy, input logic eq,
                      input logic ew, input logic [LB-1:0] eb, input logic eia,
                      input logic ela, input logic esel, input logic [PA-1:0] eadr,
                      input logic chkfb);
    vec_t v;
    v.rst = rst; v.irw = irw; v.lrw = lrw; v.ladr = ladr; v.rdy = rdy;
    v.eq = eq; v.ew = ew; v.eb = eb; v.eia = eia; v.ela = ela; v.esel = esel;
    v.eadr = eadr; v.chkfb = chkfb;
    vq.push_back(v);
  endtask

  // A cycle with no bus activity expected (IDLE or DONE).
  task automatic quiet(input logic [1:0] irw, input logic [1:0] lrw,
                       input logic [PA-1:0] ladr, input logic esel, input logic chkfb);
    push(1'b0, irw, lrw, ladr, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, esel, '0, chkfb);
  endtask

  // Eight zero-wait beats of one burst.
  task automatic burst(input logic [1:0] irw, input logic [1:0] lrw, input logic [PA-1:0] ladr,
                       input logic wr, input logic lsu, input logic [PA-1:0] base);
    for (int b = 0; b < 8; b++)
      push(1'b0, irw, lrw, ladr, 1'b1, 1'b1, wr, LB'(b), (b == 7) && !lsu,
           (b == 7) && lsu, lsu, base + PA'(8 * b), 1'b0);
  endtask

  task automatic chk(input string nm, input int row, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  task automatic chk_fb(input string nm, input int row);
    checks++;
    if (FetchBuffer !== fb_exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, FetchBuffer, fb_exp);
    end
  endtask

  task automatic apply(input vec_t v, input int row);
    @(posedge clk); #1;
    reset         = v.rst;
    IFUCacheBusRW = v.irw;
    LSUCacheBusRW = v.lrw;
    LSUCacheBusAdr = v.ladr;
    BusReady      = v.rdy;
    BusRData      = {32'hFEED_0000 + 32'(row), 32'(row) ^ 32'h5A5A_0000};
    LSUWriteData  = 64'hC0DE_0000_0000_0000 | 64'(v.eb);
    @(negedge clk);
    chk("BusReq",    row, 64'(BusReq),         64'(v.eq));
    chk("BusWrite",  row, 64'(BusWrite),       64'(v.ew));
    chk("BeatCount", row, 64'(BeatCount),      64'(v.eb));
    chk("IFUAck",    row, 64'(IFUCacheBusAck), 64'(v.eia));
    chk("LSUAck",    row, 64'(LSUCacheBusAck), 64'(v.ela));
    chk("SelBeat",   row, 64'(LSUSelBusBeat),  64'(v.esel));
    if (v.eq) chk("BusAdr", row, 64'(BusAdr), 64'(v.eadr));
    if (v.ew) chk("BusWData", row, BusWData, 64'hC0DE_0000_0000_0000 | 64'(v.eb));
    if (v.chkfb) chk_fb("FetchBuffer", row);
    if (v.rst) fb_exp = '0;
    else if (v.eq && !v.ew && v.rdy) fb_exp[int'(v.eb)*W +: W] = BusRData;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] pat;
    int         b;
    logic       got;

    reset = 1'b1; IFUCacheBusRW = '0; LSUCacheBusRW = '0; IFUCacheBusAdr = IADR;
    LSUCacheBusAdr = '0; LSUWriteData = '0; BusReady = 1'b0; BusRData = '0;
    fb_exp = '0;
    repeat (2) @(posedge clk);

    // Reset state.
    quiet(2'b00, 2'b00, '0, 1'b0, 1'b1);
    // IFU fill alone.
    quiet(2'b10, 2'b00, '0, 1'b0, 1'b0);
    burst(2'b10, 2'b00, '0, 1'b0, 1'b0, IADR);
    quiet(2'b00, 2'b00, '0, 1'b0, 1'b1);
    // Simultaneous fills: LSU first, then IFU for fairness.
    quiet(2'b10, 2'b10, 34'h1000, 1'b0, 1'b0);
    burst(2'b10, 2'b10, 34'h1000, 1'b0, 1'b1, 34'h1000);
    quiet(2'b10, 2'b00, 34'h1000, 1'b1, 1'b1);
    quiet(2'b10, 2'b00, '0, 1'b0, 1'b0);
    burst(2'b10, 2'b00, '0, 1'b0, 1'b0, IADR);
    quiet(2'b00, 2'b00, '0, 1'b0, 1'b1);
    // Writeback then fill retained by LSU, IFU asking throughout.
    quiet(2'b10, 2'b01, 34'h100, 1'b0, 1'b0);
    burst(2'b10, 2'b01, 34'h100, 1'b1, 1'b1, 34'h100);
    quiet(2'b10, 2'b10, 34'h200, 1'b1, 1'b1);
    quiet(2'b10, 2'b10, 34'h200, 1'b0, 1'b0);
    burst(2'b10, 2'b10, 34'h200, 1'b0, 1'b1, 34'h200);
    quiet(2'b10, 2'b00, '0, 1'b1, 1'b1);
    quiet(2'b10, 2'b00, '0, 1'b0, 1'b0);
    burst(2'b10, 2'b00, '0, 1'b0, 1'b0, IADR);
    quiet(2'b00, 2'b00, '0, 1'b0, 1'b1);
    // IFU fill with BusReady pattern 1,0,0,1.
    quiet(2'b10, 2'b00, '0, 1'b0, 1'b0);
    pat = 4'b1001;
    b = 0;
    for (int k = 0; b < 8; k++) begin
      logic r;
      r = pat[3 - (k % 4)];
      push(1'b0, 2'b10, 2'b00, '0, r, 1'b1, 1'b0, LB'(b), r && (b == 7), 1'b0, 1'b0,
           IADR + PA'(8 * b), 1'b0);
      if (r) b++;
    end
    quiet(2'b00, 2'b00, '0, 1'b0, 1'b1);
    quiet(2'b00, 2'b00, '0, 1'b0, 1'b0);

    for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

    // Reset at beat 3 of an LSU fill, then a re-request restarts at beat 0.
    @(posedge clk); #1;
    IFUCacheBusRW = 2'b00; LSUCacheBusRW = 2'b10; LSUCacheBusAdr = 34'h300; BusReady = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (BusReq && BeatCount == 3'd3) got = 1'b1;
      else chk("rst_noack", c, 64'(LSUCacheBusAck), 64'd0);
    end
    chk("rst_reach_beat3", 0, 64'(got), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_busreq",  0, 64'(BusReq),         64'd0);
    chk("rst_beat",    0, 64'(BeatCount),      64'd0);
    chk("rst_lsuack",  0, 64'(LSUCacheBusAck), 64'd0);
    chk("rst_ifuack",  0, 64'(IFUCacheBusAck), 64'd0);
    chk("rst_sel",     0, 64'(LSUSelBusBeat),  64'd0);
    chk("rst_buswr",   0, 64'(BusWrite),       64'd0);
    fb_exp = '0;
    chk_fb("rst_fetchbuf", 0);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("rerun_busreq", c, 64'(BusReq),         64'd1);
      chk("rerun_beat",   c, 64'(BeatCount),      64'(c));
      chk("rerun_adr",    c, 64'(BusAdr),         64'h300 + 64'(8 * c));
      chk("rerun_lsuack", c, 64'(LSUCacheBusAck), 64'(c == 7));
    end
    LSUCacheBusRW = 2'b00;
    @(negedge clk);
    chk("rerun_done_req", 0, 64'(BusReq),        64'd0);
    chk("rerun_done_sel", 0, 64'(LSUSelBusBeat), 64'd1);
    @(negedge clk);
    chk("rerun_idle_sel", 0, 64'(LSUSelBusBeat), 64'd0);

    // IFU asks during an LSU burst but withdraws before the grant.
    LSUCacheBusRW = 2'b10; LSUCacheBusAdr = 34'h400;
    @(negedge clk);
    chk("wd_lsu_grant", 0, 64'(LSUSelBusBeat), 64'd1);
    IFUCacheBusRW = 2'b10;
    repeat (3) @(negedge clk);
    IFUCacheBusRW = 2'b00;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (LSUCacheBusAck) got = 1'b1;
    end
    chk("wd_lsu_ack_seen", 0, 64'(got), 64'd1);
    LSUCacheBusRW = 2'b00;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("wd_busreq", c, 64'(BusReq),         64'd0);
      chk("wd_beat",   c, 64'(BeatCount),      64'd0);
      chk("wd_ifuack", c, 64'(IFUCacheBusAck), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
